// File: rtl/pq_shift_queue.sv
// rtl/pq_shift_queue.sv - sorted shift-register priority queue, head at entry 0
// Optional eviction-on-full behaviour is enabled by defining PQ_EVICT_EN.
module pq_shift_queue #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int MAX_FIRST = 0,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              evict_valid,
    output logic [DATA_W-1:0] evict_data
);

    logic [DATA_W-1:0] key_q [DEPTH];
    logic [DATA_W-1:0] key_d [DEPTH];
    logic [DATA_W-1:0] up    [DEPTH];
    logic [DATA_W-1:0] dn    [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DEPTH-1:0]  ge, ge_up, ge_dn;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full_q, empty_q;
    logic              ins, pop;

    function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (MAX_FIRST != 0) return a > b;
        return a < b;
    endfunction

    // ge[j]: entry j is valid and not worse than the incoming key; always a prefix
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            ge[j] = vld_q[j] & ~better(in_data, key_q[j]);
        end
    end

    assign ge_up = {1'b0, ge[DEPTH-1:1]};
    assign ge_dn = {ge[DEPTH-2:0], 1'b1};

    always_comb begin
        for (int j = 0; j < DEPTH - 1; j++) begin
            up[j] = key_q[j+1];
        end
        up[DEPTH-1] = key_q[DEPTH-1];
        dn[0] = in_data;
        for (int j = 1; j < DEPTH; j++) begin
            dn[j] = key_q[j-1];
        end
    end

`ifdef PQ_EVICT_EN
    assign in_ready = 1'b1;
`else
    assign in_ready = ~full_q;
`endif

    assign ins = in_valid & in_ready;
    assign pop = ~empty_q & out_ready;

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            key_d[j] = key_q[j];
            if (clear) begin
                key_d[j] = key_q[j];
            end else if (ins && pop) begin
                if (ge_up[j])
                    key_d[j] = up[j];
                else if (ge[j] || j == 0)
                    key_d[j] = in_data;
            end else if (ins) begin
                // A full queue with a key no better than the tail leaves every cell unchanged
                if (ge[j])
                    key_d[j] = key_q[j];
                else if (ge_dn[j])
                    key_d[j] = in_data;
                else
                    key_d[j] = dn[j];
            end else if (pop) begin
                key_d[j] = up[j];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (ins && !pop && !full_q)
            cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !ins)
            cnt_d = cnt_q - CNT_W'(1);
        for (int j = 0; j < DEPTH; j++) begin
            vld_d[j] = (CNT_W'(j) < cnt_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q   <= '{default: '0};
            vld_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            key_q   <= key_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

`ifdef PQ_EVICT_EN
    logic              ev_q, ev_d;
    logic [DATA_W-1:0] evd_q;

    assign ev_d = ins & ~pop & full_q & ~clear;

    // Either the old tail is pushed out, or the newcomer itself is rejected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_q  <= 1'b0;
            evd_q <= '0;
        end else begin
            ev_q <= ev_d;
            if (ev_d)
                evd_q <= ge[DEPTH-1] ? in_data : key_q[DEPTH-1];
        end
    end

    assign evict_valid = ev_q;
    assign evict_data  = evd_q;
`else
    assign evict_valid = 1'b0;
    assign evict_data  = '0;
`endif

    assign out_valid = ~empty_q;
    assign out_data  = key_q[0];
    assign count     = cnt_q;
    assign full      = full_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_pq_shift_queue.sv
// tb/tb_pq_shift_queue.sv - bench for pq_shift_queue: queue model plus directed vectors
module tb_pq_shift_queue;

    localparam int DW = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);
`ifdef PQ_EVICT_EN
    localparam bit EVICT = 1'b1;
`else
    localparam bit EVICT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          clr0 = 1'b0, iv0 = 1'b0, or0 = 1'b0;
    logic [DW-1:0] id0 = '0;
    logic          ir0, ov0, full0, empty0, evv0;
    logic [DW-1:0] od0, evd0;
    logic [CW-1:0] cnt0;

    logic          clr1 = 1'b0, iv1 = 1'b0, or1 = 1'b0;
    logic [DW-1:0] id1 = '0;
    logic          ir1, ov1, full1, empty1, evv1;
    logic [DW-1:0] od1, evd1;
    logic [CW-1:0] cnt1;

    int tests = 0;
    int fails = 0;

    logic [31:0] m0[$];
    logic [31:0] m1[$];
    bit          mev0 = 1'b0, mev1 = 1'b0;
    logic [31:0] mevd0 = '0, mevd1 = '0;

    logic [31:0] exp1 [4] = '{32'd3, 32'd3, 32'd7, 32'd9};
    logic [31:0] exp2 [3] = '{32'd5, 32'd6, 32'd8};
    logic [31:0] exp6 [4] = '{32'd1, 32'd4, 32'd5, 32'd6};

    pq_shift_queue #(.DATA_W(DW), .DEPTH(D), .MAX_FIRST(0)) u0 (
        .clk(clk), .rst(rst), .clear(clr0),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .count(cnt0), .full(full0), .empty(empty0),
        .evict_valid(evv0), .evict_data(evd0)
    );

    pq_shift_queue #(.DATA_W(DW), .DEPTH(D), .MAX_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .clear(clr1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .count(cnt1), .full(full1), .empty(empty1),
        .evict_valid(evv1), .evict_data(evd1)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit better(input logic [31:0] a, input logic [31:0] b, input bit mf);
        return mf ? (a > b) : (a < b);
    endfunction

    // Model: a sorted list; a simultaneous pop happens before the insert lands
    task automatic step(inout logic [31:0] q[$], inout bit ev, inout logic [31:0] evd,
                        input bit mf, input logic clr, input logic iv, input logic ordy,
                        input logic [31:0] d);
        int p;
        bit do_pop;
        bit do_ins;
        ev = 1'b0;
        if (clr) begin
            q.delete();
            return;
        end
        do_pop = (q.size() > 0) && ordy;
        do_ins = iv && (EVICT || q.size() < D);
        if (do_pop) void'(q.pop_front());
        if (do_ins) begin
            p = 0;
            foreach (q[i]) if (!better(d, q[i], mf)) p++;
            q.insert(p, d);
            if (q.size() > D) begin
                evd = q.pop_back();
                ev  = 1'b1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0.delete(); mev0 = 1'b0; mevd0 = '0;
            m1.delete(); mev1 = 1'b0; mevd1 = '0;
        end else begin
            step(m0, mev0, mevd0, 1'b0, clr0, iv0, or0, id0);
            step(m1, mev1, mevd1, 1'b1, clr1, iv1, or1, id1);
        end
    end

    task automatic cmp(input string n, input logic [31:0] q[$], input bit ev, input logic [31:0] evd,
                       input logic ov, input logic [31:0] od, input logic [CW-1:0] c,
                       input logic fu, input logic em, input logic ir,
                       input logic evv, input logic [31:0] evdd);
        chk({n, " out_valid"}, 32'(ov), 32'(q.size() != 0));
        if (q.size() != 0) chk({n, " out_data"}, od, q[0]);
        chk({n, " count"}, 32'(c), 32'(q.size()));
        chk({n, " full"}, 32'(fu), 32'(q.size() == D));
        chk({n, " empty"}, 32'(em), 32'(q.size() == 0));
        chk({n, " in_ready"}, 32'(ir), 32'(EVICT || q.size() < D));
        chk({n, " evict_valid"}, 32'(evv), 32'(ev));
        if (ev) chk({n, " evict_data"}, evdd, evd);
    endtask

    always @(negedge clk) begin
        cmp("u0", m0, mev0, mevd0, ov0, od0, cnt0, full0, empty0, ir0, evv0, evd0);
        cmp("u1", m1, mev1, mevd1, ov1, od1, cnt1, full1, empty1, ir1, evv1, evd1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ins0(input logic [31:0] d);
        iv0 = 1'b1;
        id0 = d;
        tick();
    endtask

    task automatic ins1(input logic [31:0] d);
        iv1 = 1'b1;
        id1 = d;
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst out_valid", 32'(ov0), 32'd0);
        chk("rst count", 32'(cnt0), 32'd0);
        chk("rst empty", 32'(empty0), 32'd1);
        chk("rst full", 32'(full0), 32'd0);
        chk("rst out_data", od0, 32'd0);
        chk("rst evict_valid", 32'(evv0), 32'd0);
        chk("rst evict_data", evd0, 32'd0);
        rst = 1'b0;

        ins0(7); ins0(3); ins0(9); ins0(3);
        iv0 = 1'b0;
        chk("fill head", od0, 32'd3);
        chk("fill count", 32'(cnt0), 32'd4);
        chk("fill full", 32'(full0), 32'd1);
        chk("fill in_ready", 32'(ir0), 32'(EVICT));
`ifndef PQ_EVICT_EN
        ins0(0);
        iv0 = 1'b0;
        chk("full drop head", od0, 32'd3);
        chk("full drop count", 32'(cnt0), 32'd4);
`endif
        or0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain1 head", od0, exp1[i]);
            tick();
        end
        or0 = 1'b0;
        chk("drain1 empty", 32'(empty0), 32'd1);

        ins0(2); ins0(5); ins0(8);
        id0 = 1; or0 = 1'b1;
        tick();
        chk("swap1 head", od0, 32'd1);
        chk("swap1 count", 32'(cnt0), 32'd3);
        id0 = 6;
        tick();
        chk("swap6 head", od0, 32'd5);
        chk("swap6 count", 32'(cnt0), 32'd3);
        iv0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain2 head", od0, exp2[i]);
            tick();
        end
        or0 = 1'b0;
        chk("drain2 empty", 32'(empty0), 32'd1);

        ins1(32'h10); ins1(32'hFFFF_FFFF); ins1(32'h0);
        iv1 = 1'b0;
        chk("max head", od1, 32'hFFFF_FFFF);
        chk("max out_valid", 32'(ov1), 32'd1);
        chk("max count", 32'(cnt1), 32'd3);
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
        chk("max next head", od1, 32'h10);
        chk("max next count", 32'(cnt1), 32'd2);

        ins0(4); ins0(1); ins0(2);
        clr0 = 1'b1; iv0 = 1'b1; id0 = 0; or0 = 1'b1;
        tick();
        clr0 = 1'b0; iv0 = 1'b0; or0 = 1'b0;
        chk("clear count", 32'(cnt0), 32'd0);
        chk("clear empty", 32'(empty0), 32'd1);
        chk("clear out_valid", 32'(ov0), 32'd0);
        tick();
        chk("clear hold count", 32'(cnt0), 32'd0);

        ins0(32'h20); ins0(32'h30); ins0(32'h40); ins0(32'h50);
        chk("burst full", 32'(full0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async out_valid", 32'(ov0), 32'd0);
        chk("async count", 32'(cnt0), 32'd0);
        chk("async full", 32'(full0), 32'd0);
        chk("async u1 out_valid", 32'(ov1), 32'd0);
        iv0 = 1'b0;
        tick();
        rst = 1'b0;
        ins0(32'h55);
        iv0 = 1'b0;
        chk("post rst head", od0, 32'h55);
        chk("post rst out_valid", 32'(ov0), 32'd1);
        chk("post rst count", 32'(cnt0), 32'd1);

`ifdef PQ_EVICT_EN
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        ins0(9); ins0(1); ins0(6); ins0(4);
        ins0(5);
        chk("evict5 valid", 32'(evv0), 32'd1);
        chk("evict5 data", evd0, 32'd9);
        chk("evict5 head", od0, 32'd1);
        chk("evict5 count", 32'(cnt0), 32'd4);
        ins0(12);
        chk("evict12 valid", 32'(evv0), 32'd1);
        chk("evict12 data", evd0, 32'd12);
        chk("evict12 count", 32'(cnt0), 32'd4);
        iv0 = 1'b0;
        tick();
        chk("evict pulse end", 32'(evv0), 32'd0);
        or0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain evict head", od0, exp6[i]);
            tick();
        end
        or0 = 1'b0;
`endif
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pq_shift_queue.md
Name: pq_shift_queue

Overview:
- Parametrised shift-register priority queue for QuickQ; successor to the single-slot compare/route stage.
- Holds up to DEPTH keys in sorted order, so the best key is always at entry 0.
- Every cell compares against the incoming key in parallel, so insert and remove each complete in one cycle.
- Sits between the scheduler front end (producer) and the dispatch logic (consumer), using valid/ready handshakes on both sides.

Parameters:
- DATA_W, 32, key width in bits.
- DEPTH, 16, number of entries; must be 2 or more.
- MAX_FIRST, 0. When 0, the smallest key is at the head. When 1, the largest key is at the head.
- CNT_W, $clog2(DEPTH+1), width of the count output. Derived; do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; empties the queue on the next edge.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  queue accepts an insert this cycle.
- in_data  in  DATA_W  key to insert.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer removes the head this cycle.
- out_data  out  DATA_W  head key.
- count  out  CNT_W  number of valid entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- evict_valid  out  1  one-cycle pulse: an entry was evicted (only with the optional feature).
- evict_data  out  DATA_W  evicted key.

Behaviour:
- Storage and flags:
  - Storage is key[0..DEPTH-1] plus a valid bit per entry. Valid entries are contiguous from index 0.
  - There is no sentinel value; all-ones is a legal key.
- Reset (rst high, asynchronous): all valid bits 0, all keys 0, count 0, empty 1, full 0, evict_valid 0, evict_data 0.
- Outputs:
  - out_valid = ~empty; out_data = key[0]. Both are driven from registers, with no combinational path from inputs.
  - in_ready = ~full, from registered state only; it does not depend on out_ready.
- Handshakes: ins = in_valid & in_ready; pop = out_valid & out_ready.
- Ordering ("better" means less-than when MAX_FIRST=0, greater-than when MAX_FIRST=1):
  - p = number of valid entries that are not worse than in_data.
  - Equal keys keep FIFO order: a new key is placed after existing equal keys.
- Next state on each edge, indexes j:
  - ins only: new[j]=old[j] for j<p; new[p]=in_data; new[j]=old[j-1] for j>p; count+1.
  - pop only: new[j]=old[j+1]; last slot becomes invalid; count-1.
  - ins and pop together, p==0: new[0]=in_data; rest unchanged; count unchanged.
  - ins and pop together, p>=1: new[j]=old[j+1] for j<p-1; new[p-1]=in_data; new[j]=old[j] for j>=p; count unchanged.
  - neither: hold.
- Latency: an accepted key appears on out_data the cycle after acceptance if it becomes the head. After a pop, the next head is visible the following cycle.
- Boundaries:
  - Pop while empty: impossible, because out_valid=0.
  - Insert while full: in_ready=0, data not taken (unless PQ_EVICT_EN).
  - full and empty are recomputed from next count, so they are exact every cycle.
- clear:
  - Has priority over ins and pop in the same cycle; the handshakes are ignored.
  - Result: all valid bits 0, count 0, evict_valid 0.
- rst asserted mid-operation: state is lost immediately; outputs take reset values asynchronously.

Optional Feature:
- Macro: PQ_EVICT_EN.
- Defined:
  - in_ready is forced to 1.
  - Insert while full, pop=0, in_data better than key[DEPTH-1]: key is inserted at p, the old key[DEPTH-1] is dropped, evict_valid=1 and evict_data=old tail for one cycle, count stays DEPTH.
  - Insert while full, in_data not better than the tail: in_data itself is evicted (evict_valid=1, evict_data=in_data) and the queue is unchanged.
  - Insert while full with pop: normal simultaneous rule, no eviction.
- Undefined: evict_valid and evict_data are tied to 0; in_ready = ~full.

Test Plan:
- DEPTH=4, MAX_FIRST=0. Insert 7, 3, 9, 3' (second 3, tagged via its arrival order), one per cycle, out_ready=0 → out_data=3, count=4, full=1, in_ready=0. Then pop ×4 → out_data sequence 3, 3' (FIFO among equals), 7, 9; then empty=1.
- Queue {2,5,8}. Simultaneous insert 1 and pop → 2 removed, new head 1, contents {1,5,8}, count=3. Simultaneous insert 6 and pop → {5,6,8}.
- MAX_FIRST=1. Insert 0x10, 0xFFFFFFFF, 0x0 → out_data=0xFFFFFFFF and it pops first (all-ones is a legal key, not empty).
- Queue holds 3 entries. Assert clear together with in_valid=1 and out_ready=1 → next cycle count=0, empty=1, out_valid=0, no entry stored.
- Assert rst asynchronously mid-insert-burst → out_valid, count and full drop to 0 before the next clk edge. After release, a single insert of 0x55 gives out_data=0x55 next cycle.
- PQ_EVICT_EN, DEPTH=4, queue full {1,4,6,9}:
  - insert 5 → {1,4,5,6}, evict_valid pulse, evict_data=9.
  - then insert 12 → queue unchanged, evict_data=12.
